vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameters V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33, vertical timing in lines.
REQ-004 SHALL have parameter COLOR_BITS, 4, bits per colour channel; pixel word = {R,G,B} in q[3*COLOR_BITS-1:0].
REQ-005 SHALL have parameter ADDR_WIDTH, 16, framebuffer address width.
REQ-006 SHALL have parameter DATA_WIDTH, 16, framebuffer word width (>= 3*COLOR_BITS).
REQ-007 SHALL have parameter SCALE_SHIFT, 0, pixel replication of 2^SCALE_SHIFT in both axes.
REQ-008 SHALL have parameter RD_LATENCY, 1, clocks from addr to valid data on q (>= 1).
REQ-009 SHALL have parameter SYNC_POL, 0, active level of hs/vs (0 = active-low).
REQ-010 SHALL have ports: clock in 1 pixel clock; clear in 1 reset, asynchronous and active-low.
REQ-011 SHALL have ports: enable in 1 video on; base_addr in ADDR_WIDTH framebuffer origin.
REQ-012 SHALL have ports: addr out ADDR_WIDTH framebuffer read address; q in DATA_WIDTH read data.
REQ-013 SHALL have ports: VGA_R, VGA_G, VGA_B out COLOR_BITS each; VGA_HS, VGA_VS out 1; frame_start out 1.

Function
REQ-014 SHALL run h counter 0..H_TOTAL-1 (H_TOTAL = sum of H params) and v counter 0..V_TOTAL-1, v advancing when h wraps, both wrapping to 0.
REQ-015 SHALL define hsync active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, vsync active likewise on v; visible when h < H_VISIBLE and v < V_VISIBLE.
REQ-016 SHALL sample base_addr into line_base only at h=0,v=0; changes mid-frame have no effect until next frame.
REQ-017 SHALL drive addr = line_base + (h >> SCALE_SHIFT) while visible, and hold line_base during blanking; sums wrap mod 2^ADDR_WIDTH.
REQ-018 SHALL advance line_base by H_VISIBLE >> SCALE_SHIFT at the end of each visible line whose v[SCALE_SHIFT-1:0] is all ones (every line if SCALE_SHIFT=0), with no multiplier.
REQ-019 SHALL delay visible/hsync/vsync/frame flags through a pipeline of RD_LATENCY+1 registers so all outputs for pixel (h,v) appear together, registered.
REQ-020 SHALL output q colour fields when delayed-visible and enable=1, else all colour outputs 0.
REQ-021 SHALL keep counters and syncs running when enable=0.
REQ-022 SHALL pulse frame_start high for one clock aligned with output of pixel (0,0).

Reset
REQ-023 SHALL, on clear low, asynchronously set h=v=0, line_base=0, addr=0, pipeline cleared, colours 0, VGA_HS=VGA_VS=~SYNC_POL, frame_start=0.
REQ-024 SHALL, on the first clock edge after clear deasserts, treat the counter state as pixel (0,0) and sample base_addr.
REQ-025 SHALL hold all outputs at reset values for the first RD_LATENCY+1 clocks after release.

Verification
REQ-026 Defaults, run 2 frames -> VGA_HS active-low for 96 of every 800 clocks; VGA_VS low for 1600 of every 420000 clocks; frame_start period 420000.
REQ-027 SCALE_SHIFT=2, base_addr=0x4000 -> line 0 addr 0x4000..0x409F, lines 0-3 identical, line 4 starts 0x40A0, last visible addr 0x8AFF.
REQ-028 RD_LATENCY=2, memory model returns q=addr[11:0] -> output colour at pixel (x,y) equals low 12 bits of addr issued for (x,y); colours 0 throughout blanking.
REQ-029 base_addr changed 0x0000->0x1000 at v=200 -> remainder of frame continues from 0x0000; next frame line 0 starts 0x1000.
REQ-030 clear asserted at h=300,v=200 -> all outputs reset values same cycle (async); after release frame_start occurs RD_LATENCY+1 clocks later and hsync at h=656.
REQ-031 enable=0 for one full frame -> colours 0 every cycle, VGA_HS/VGA_VS timing unchanged vs REQ-026.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Framebuffer read bus between the scanout engine (master) and a synchronous
// memory (slave) that returns q a fixed number of clocks after addr.
interface vga_scanout_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] q;

  modport master (output addr, input q);
  modport slave  (input addr, output q);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster scanout: timing counters, framebuffer address generation with
// pixel replication, and a flag pipeline matched to the memory read latency.
module vga_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int COLOR_BITS  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_SHIFT = 0,
  parameter int RD_LATENCY  = 1,
  parameter int SYNC_POL    = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  vga_scanout_if.master         fb,
  output logic [COLOR_BITS-1:0] VGA_R,
  output logic [COLOR_BITS-1:0] VGA_G,
  output logic [COLOR_BITS-1:0] VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_VISIBLE >> SCALE_SHIFT);
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0]         h_p0;
  logic [VW-1:0]         v_p0;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [RD_LATENCY:0]   vld_p, hs_p, vs_p, fs_p;

  int                    h_i, v_i;
  logic                  vis_c, hs_c, vs_c, first_c, line_end_c;
  logic [ADDR_WIDTH-1:0] lb_eff, col_c;

  always_comb begin
    h_i        = int'(h_p0);
    v_i        = int'(v_p0);
    vis_c      = (h_i < H_VISIBLE) && (v_i < V_VISIBLE);
    hs_c       = (h_i >= H_VISIBLE + H_FRONT) && (h_i < H_VISIBLE + H_FRONT + H_SYNC);
    vs_c       = (v_i >= V_VISIBLE + V_FRONT) && (v_i < V_VISIBLE + V_FRONT + V_SYNC);
    first_c    = (h_p0 == '0) && (v_p0 == '0);
    // Last visible pixel of the final replicated copy of a source line.
    line_end_c = (h_i == H_VISIBLE - 1) && (v_i < V_VISIBLE) && ((v_p0 & V_MASK) == V_MASK);
    // The origin is taken straight from base_addr on the first pixel of a frame.
    lb_eff     = first_c ? base_addr : line_base;
    col_c      = ADDR_WIDTH'(h_p0 >> SCALE_SHIFT);
  end

  // Stage p0: raster counters, address issue, flag pipeline entry
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      h_p0      <= '0;
      v_p0      <= '0;
      line_base <= '0;
      addr_p0   <= '0;
      vld_p     <= '0;
      hs_p      <= '0;
      vs_p      <= '0;
      fs_p      <= '0;
    end else begin
      if (h_p0 == H_LAST) begin
        h_p0 <= '0;
        v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + VW'(1);
      end else begin
        h_p0 <= h_p0 + HW'(1);
      end
      line_base <= line_end_c ? lb_eff + LINE_STEP : lb_eff;
      addr_p0   <= vis_c ? lb_eff + col_c : lb_eff;
      vld_p     <= {vld_p[RD_LATENCY-1:0], vis_c};
      hs_p      <= {hs_p[RD_LATENCY-1:0], hs_c};
      vs_p      <= {vs_p[RD_LATENCY-1:0], vs_c};
      fs_p      <= {fs_p[RD_LATENCY-1:0], first_c};
    end
  end

  assign fb.addr = addr_p0;

  // Output stage: read data and delayed flags for the same pixel meet here
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~SYNC_ACT;
      VGA_VS      <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      if (vld_p[RD_LATENCY] && enable) begin
        VGA_R <= fb.q[3*COLOR_BITS-1 -: COLOR_BITS];
        VGA_G <= fb.q[2*COLOR_BITS-1 -: COLOR_BITS];
        VGA_B <= fb.q[COLOR_BITS-1:0];
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
      VGA_HS      <= hs_p[RD_LATENCY] ? SYNC_ACT : ~SYNC_ACT;
      VGA_VS      <= vs_p[RD_LATENCY] ? SYNC_ACT : ~SYNC_ACT;
      frame_start <= fs_p[RD_LATENCY];
    end
  end

  generate
    if (DATA_WIDTH > 3*COLOR_BITS) begin : g_spare
      logic unused_q_hi;
      assign unused_q_hi = ^fb.q[DATA_WIDTH-1:3*COLOR_BITS];
    end
  endgenerate
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster with 2x replication and a
// two-clock memory; a frame-level address model predicts every output cycle.
module tb_vga_scanout;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
  localparam int S = 1, RDL = 2, AW = 16, DW = 16, CB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          clear;
  logic          enable;
  logic [AW-1:0] base_addr;
  logic [CB-1:0] r, g, b;
  logic          hs_o, vs_o, fs_o;

  int            npass = 0;
  int            ntotal = 0;
  int            mh = 0;
  int            mv = 0;
  logic [AW-1:0] fbase = '0;

  typedef struct packed {
    logic          vis;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [AW-1:0] a;
  } ent_t;
  ent_t pq[$];

  logic [AW-1:0] rd_pipe [RDL];

  vga_scanout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fb ();

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLOR_BITS(CB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SCALE_SHIFT(S), .RD_LATENCY(RDL), .SYNC_POL(0)
  ) dut (
    .clock(clk), .clear(clear), .enable(enable), .base_addr(base_addr),
    .fb(fb),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs_o), .VGA_VS(vs_o), .frame_start(fs_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd977;
    return t[23:8];
  endfunction

  // Synchronous memory with RDL clocks of read latency
  always @(posedge clk) begin
    rd_pipe[0] <= fb.addr;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb.q = mem_word(rd_pipe[RDL-1]);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s at h=%0d v=%0d: got %0h expected %0h", tag, mh, mv, obs, exp);
  endtask

  // Compare the video outputs against the pixel entry e (all-zero entry = idle/reset)
  task automatic check_out(input ent_t e, input logic en);
    logic [DW-1:0] w;
    w = mem_word(e.a);
    check("red",   16'(r), (e.vis && en) ? 16'(w[11:8]) : 16'h0);
    check("green", 16'(g), (e.vis && en) ? 16'(w[7:4])  : 16'h0);
    check("blue",  16'(b), (e.vis && en) ? 16'(w[3:0])  : 16'h0);
    check("hsync", 16'(hs_o), e.hs ? 16'h0 : 16'h1);
    check("vsync", 16'(vs_o), e.vs ? 16'h0 : 16'h1);
    check("frame_start", 16'(fs_o), 16'(e.fs));
  endtask

  // One pixel clock: predict the pixel the DUT is at, clock, compare
  task automatic tick(input logic en, input logic [AW-1:0] ba);
    ent_t e;
    int   t, ld;
    enable    = en;
    base_addr = ba;
    if (mh == 0 && mv == 0) fbase = ba;
    e.vis = (mh < HV) && (mv < VV);
    e.hs  = (mh >= HV + HF) && (mh < HV + HF + HS);
    e.vs  = (mv >= VV + VF) && (mv < VV + VF + VS);
    e.fs  = (mh == 0) && (mv == 0);
    if (e.vis) begin
      t = int'(fbase) + (mv >> S) * (HV >> S) + (mh >> S);
    end else begin
      ld = (mh >= HV) ? mv + 1 : mv;
      if (ld > VV) ld = VV;
      t = int'(fbase) + (ld >> S) * (HV >> S);
    end
    e.a = t[AW-1:0];
    pq.push_back(e);
    @(posedge clk);
    #1;
    check("addr", fb.addr, e.a);
    if (pq.size() == RDL + 2) check_out(pq.pop_front(), en);
    else check_out('0, en);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  initial begin
    clear     = 1'b0;
    enable    = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", fb.addr, 16'h0);
    check_out('0, 1'b1);
    #2 clear = 1'b1;

    // Random base_addr every clock: only the value at (0,0) may take effect
    for (int i = 0; i < 3 * FRAME; i++) tick(1'b1, 16'($urandom));
    // Video off for a whole frame: timing continues, colours stay dark
    for (int i = 0; i < FRAME; i++) tick(1'b0, 16'($urandom));
    for (int i = 0; i < FRAME; i++) tick(1'($urandom_range(0, 1)), 16'($urandom));
    // Origin near the top of the address space wraps within the frame
    for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 16'hFFF8);
    for (int i = 0; i < 4 * HT + 11; i++) tick(1'b1, 16'h1234);

    // Asynchronous clear in the middle of a visible line
    clear = 1'b0;
    #1;
    check("clear_addr", fb.addr, 16'h0);
    check_out('0, 1'b1);
    #2 clear = 1'b1;
    mh = 0;
    mv = 0;
    pq.delete();
    for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 16'($urandom));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
